// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB down-counter timer: register offsets,
// CTRL bit positions and the CTRL register layout.
package apb_timer_pkg;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned PSC_MAX_W = 16;

   localparam logic [3:0] ADDR_CTRL   = 4'h0;
   localparam logic [3:0] ADDR_LOAD   = 4'h4;
   localparam logic [3:0] ADDR_COUNT  = 4'h8;
   localparam logic [3:0] ADDR_STATUS = 4'hC;

   localparam logic [1:0] REG_CTRL   = ADDR_CTRL[3:2];
   localparam logic [1:0] REG_LOAD   = ADDR_LOAD[3:2];
   localparam logic [1:0] REG_COUNT  = ADDR_COUNT[3:2];
   localparam logic [1:0] REG_STATUS = ADDR_STATUS[3:2];

   localparam int unsigned CTRL_EN_BIT     = 0;
   localparam int unsigned CTRL_AUTO_BIT   = 1;
   localparam int unsigned CTRL_IRQ_EN_BIT = 2;
   localparam int unsigned CTRL_PSC_LSB    = 8;

   // Bit-exact image of CTRL[23:0]; psc bits above PSC_W are kept at 0.
   typedef struct packed {
      logic [PSC_MAX_W-1:0] psc;
      logic [4:0]           rsvd;
      logic                 irq_en;
      logic                 auto_rl;
      logic                 en;
   } ctrl_t;

endpackage

// File: rtl/apb_timer_prescaler.sv
// Prescaler for the APB timer: counts 0..psc while enabled and flags a
// tick on the terminal cycle.
module apb_timer_prescaler #(
   parameter int unsigned PSC_W = 8
) (
   input  logic             hclk,
   input  logic             hresetn,
   input  logic             en,
   input  logic [PSC_W-1:0] psc,
   output logic             tick_c
);

   logic [PSC_W-1:0] psc_cnt_q;
   logic [PSC_W-1:0] psc_cnt_d;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) psc_cnt_q <= '0;
      else          psc_cnt_q <= psc_cnt_d;
   end

   always_comb begin
      tick_c    = 1'b0;
      psc_cnt_d = '0;
      if (en) begin
         if (psc_cnt_q == psc) tick_c = 1'b1;
         else                  psc_cnt_d = psc_cnt_q + PSC_W'(1);
      end
   end

endmodule

// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB timer slave: 32-bit prescaled down-counter with
// one-shot / auto-reload modes and a registered level interrupt.
module apb_timer_slave
   import apb_timer_pkg::*;
#(
   parameter int unsigned PSC_W = 8
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [DATA_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              irq
);

   ctrl_t             ctrl_q,   ctrl_d;
   logic [DATA_W-1:0] load_q,   load_d;
   logic [DATA_W-1:0] count_q,  count_d;
   logic              exp_q,    exp_d;
   logic              irq_q,    irq_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;

   logic        tick_c;
   logic        expire_c;
   logic        wr_commit_c;
   logic        rd_setup_c;
   logic [1:0]  reg_sel_c;
   ctrl_t       ctrl_wr_c;
   logic        unused_paddr_c;

   assign unused_paddr_c = ^{paddr[DATA_W-1:4], paddr[1:0]};

   apb_timer_prescaler #(.PSC_W(PSC_W)) u_prescaler (
      .hclk    (hclk),
      .hresetn (hresetn),
      .en      (ctrl_q.en),
      .psc     (ctrl_q.psc[PSC_W-1:0]),
      .tick_c  (tick_c)
   );

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         ctrl_q   <= '0;
         load_q   <= '0;
         count_q  <= '0;
         exp_q    <= 1'b0;
         irq_q    <= 1'b0;
         prdata_q <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         load_q   <= load_d;
         count_q  <= count_d;
         exp_q    <= exp_d;
         irq_q    <= irq_d;
         prdata_q <= prdata_d;
      end
   end

   always_comb begin
      wr_commit_c = psel & penable & pwrite;
      rd_setup_c  = psel & ~penable & ~pwrite;
      reg_sel_c   = paddr[3:2];
      expire_c    = tick_c & (count_q == '0);

      ctrl_wr_c         = '0;
      ctrl_wr_c.en      = pwdata[CTRL_EN_BIT];
      ctrl_wr_c.auto_rl = pwdata[CTRL_AUTO_BIT];
      ctrl_wr_c.irq_en  = pwdata[CTRL_IRQ_EN_BIT];
      ctrl_wr_c.psc     = PSC_MAX_W'(pwdata[CTRL_PSC_LSB +: PSC_W]);

      ctrl_d   = ctrl_q;
      load_d   = load_q;
      count_d  = count_q;
      exp_d    = exp_q;
      irq_d    = exp_q & ctrl_q.irq_en;
      prdata_d = prdata_q;

      // Counter step; bus writes below take precedence over it.
      if (tick_c) begin
         if (!expire_c) begin
            count_d = count_q - DATA_W'(1);
         end else if (ctrl_q.auto_rl) begin
            count_d = load_q;
         end else begin
            ctrl_d.en = 1'b0;
         end
      end

      if (wr_commit_c) begin
         case (reg_sel_c)
            REG_CTRL:   ctrl_d = ctrl_wr_c;
            REG_LOAD: begin
               load_d  = pwdata;
               count_d = pwdata;
            end
            REG_STATUS: if (pwdata[0]) exp_d = 1'b0;
            default: ;
         endcase
      end

      // An expiry on the same edge as a W1C keeps EXP set.
      if (expire_c) exp_d = 1'b1;

      if (rd_setup_c) begin
         case (reg_sel_c)
            REG_CTRL:   prdata_d = DATA_W'(ctrl_q);
            REG_LOAD:   prdata_d = load_q;
            REG_COUNT:  prdata_d = count_q;
            REG_STATUS: prdata_d = DATA_W'(exp_q);
            default:    prdata_d = '0;
         endcase
      end
   end

   assign prdata = prdata_q;
   assign irq    = irq_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave: APB reads/writes with hand-computed
// expected register values and interrupt levels.
module tb_apb_timer_slave;

   logic        hclk    = 1'b0;
   logic        hresetn = 1'b0;
   logic        psel    = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite  = 1'b0;
   logic [31:0] paddr   = '0;
   logic [31:0] pwdata  = '0;
   logic [31:0] prdata;
   logic        irq;

   int vectors     = 0;
   int miscompares = 0;

   always #5 hclk = ~hclk;

   apb_timer_slave #(.PSC_W(8)) dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .irq     (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Entered and left on a falling edge; commit is the rising edge in between.
   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
      @(negedge hclk);
      penable = 1'b1;
      @(negedge hclk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
      @(negedge hclk);
      penable = 1'b1;
      data = prdata;
      @(negedge hclk);
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      apb_read(addr, d);
      check(tag, d, exp);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge hclk);
      check("rst_prdata", prdata, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      hresetn = 1'b1;
      @(negedge hclk);
      rd_chk("rst_ctrl",   32'h0, 32'h0);
      rd_chk("rst_load",   32'h4, 32'h0);
      rd_chk("rst_count",  32'h8, 32'h0);
      rd_chk("rst_status", 32'hC, 32'h0);

      // Auto-reload, PSC 0: commit C; reads at setup C+1, C+3, C+5
      apb_write(32'h4, 32'd5);
      apb_write(32'h0, 32'h0000_0007);
      rd_chk("auto_cnt5", 32'h8, 32'd5);
      rd_chk("auto_cnt3", 32'h8, 32'd3);
      rd_chk("auto_cnt1", 32'h8, 32'd1);
      check("irq_before_exp", 32'(irq), 32'h0);    // EXP set at C+6, irq not yet
      rd_chk("auto_exp", 32'hC, 32'h1);
      check("irq_after_exp", 32'(irq), 32'h1);
      // CTRL=IRQ_EN only commits at C+10: count 5(C+6),4,3,2,1(C+10)
      apb_write(32'h0, 32'h0000_0004);
      rd_chk("stop_count", 32'h8, 32'd1);
      rd_chk("ctrl_irqen", 32'h0, 32'h0000_0004);

      // W1C with no expiry: irq drops one cycle after EXP clears
      apb_write(32'hC, 32'h1);
      check("irq_hold", 32'(irq), 32'h1);
      @(negedge hclk);
      check("irq_drop", 32'(irq), 32'h0);
      rd_chk("w1c_status", 32'hC, 32'h0);

      // One-shot, PSC 3: ticks at O+4, O+8, O+12, expiry at O+16
      apb_write(32'h4, 32'd3);
      apb_write(32'h0, 32'h0000_0301);
      repeat (10) @(negedge hclk);
      rd_chk("os_cnt1", 32'h8, 32'd1);
      repeat (4) @(negedge hclk);
      rd_chk("os_ctrl_en_clr", 32'h0, 32'h0000_0300);
      rd_chk("os_cnt0",        32'h8, 32'd0);
      rd_chk("os_exp",         32'hC, 32'h1);
      repeat (8) @(negedge hclk);
      rd_chk("os_cnt_stays0",  32'h8, 32'd0);
      check("os_irq_masked", 32'(irq), 32'h0);

      // LOAD=0 with AUTO expires every tick; W1C on an expiry edge loses
      apb_write(32'h4, 32'd0);
      apb_write(32'hC, 32'h1);
      apb_write(32'h0, 32'h0000_0003);
      apb_write(32'hC, 32'h1);
      rd_chk("w1c_vs_exp", 32'hC, 32'h1);
      rd_chk("alias_ctrl",   32'h10, 32'h0000_0003);
      rd_chk("alias_status", 32'h1C, 32'h1);
      apb_write(32'h0, 32'h0);
      apb_write(32'hC, 32'h1);
      rd_chk("stopped_status", 32'hC, 32'h0);

      // LOAD write on a tick edge (Q+2): no decrement that cycle
      apb_write(32'h4, 32'h100);
      apb_write(32'h0, 32'h1);
      apb_write(32'h4, 32'h10);
      rd_chk("load_on_tick", 32'h8, 32'h10);
      rd_chk("load_value",   32'h4, 32'h10);
      // Stop commits at Q+8: 0x10 - 6 = 0xA; COUNT writes ignored
      apb_write(32'h0, 32'h0);
      apb_write(32'h8, 32'h0000_DEAD);
      rd_chk("count_ro", 32'h8, 32'hA);

      // Unimplemented CTRL bits read as 0
      apb_write(32'h0, 32'hFFFF_FFF8);
      rd_chk("ctrl_mask", 32'h0, 32'h0000_FF00);

      // Reset during the access phase of a LOAD write
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h55;
      @(negedge hclk);
      penable = 1'b1;
      #2 hresetn = 1'b0;
      #1 check("rst_async_prdata", prdata, 32'h0);
      @(negedge hclk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      hresetn = 1'b1;
      @(negedge hclk);
      check("rst_mid_prdata", prdata, 32'h0);
      check("rst_mid_irq", 32'(irq), 32'h0);
      rd_chk("rst_mid_load",  32'h4, 32'h0);
      rd_chk("rst_mid_ctrl",  32'h0, 32'h0);
      rd_chk("rst_mid_count", 32'h8, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
